// File: rtl/code_convert_seq.sv
// Binary to BCD / Gray / XS-3 / XS-5 converter; decimal modes use a bit-serial double dabble engine.
// Latency: Gray 1 cycle, decimal WIDTH+1 cycles; in_ready low until result taken, out_ready low holds DONE.
module code_convert_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic [1:0]            out_mode,
  output logic                  overflow
);

  localparam int OW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] MODE_BCD  = 2'b00;
  localparam logic [1:0] MODE_GRAY = 2'b01;
  localparam logic [1:0] MODE_XS3  = 2'b10;

  if (WIDTH < 1 || WIDTH > 32) begin : g_width_chk
    $error("code_convert_seq: WIDTH must be in 1..32");
  end
  if (4 * DIGITS < WIDTH) begin : g_digits_chk
    $error("code_convert_seq: 4*DIGITS must be >= WIDTH");
  end

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [OW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             ovf_q, ovf_d;
  logic [OW-1:0]    out_q, out_d;

  logic [OW-1:0]    acc_adj;
  logic [OW-1:0]    acc_next;
  logic [OW-1:0]    acc_excess;
  logic [3:0]       excess;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 2'b00;
      ovf_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
      out_q   <= out_d;
    end
  end

  // Per-digit datapath: add-3 before each shift, and excess added to the final digits without carry.
  always_comb begin
    acc_adj    = '0;
    acc_excess = '0;
    excess     = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      acc_adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
    end
    acc_next = {acc_adj[OW-2:0], shreg_q[WIDTH-1]};
    if (mode_q == MODE_XS3) begin
      excess = 4'd3;
    end else if (mode_q != MODE_BCD) begin
      excess = 4'd5;
    end
    for (int i = 0; i < DIGITS; i++) begin
      acc_excess[4*i +: 4] = acc_next[4*i +: 4] + excess;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mode_d = in_mode;
          ovf_d  = 1'b0;
          if (in_mode == MODE_GRAY) begin
            out_d   = OW'(in_data ^ (in_data >> 1));
            state_d = DONE;
          end else begin
            shreg_d = in_data;
            acc_d   = '0;
            cnt_d   = CW'(WIDTH);
            state_d = CONV;
          end
        end
      end
      CONV: begin
        acc_d   = acc_next;
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q - CW'(1);
        // A one leaving the top digit means the value does not fit; the kept digits are value mod 10^DIGITS.
        if (acc_adj[OW-1]) begin
          ovf_d = 1'b1;
        end
        if (cnt_q == CW'(1)) begin
          out_d   = acc_excess;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_q;
  assign out_mode  = mode_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_code_convert_seq.sv
// Bench for code_convert_seq: default (8-bit, 3 digits) and 2-digit instances, vector table, corner sequences, random.
module tb_code_convert_seq;

  logic        clk;
  logic        rst;
  logic        in_valid [2];
  logic [7:0]  in_data  [2];
  logic [1:0]  in_mode  [2];
  logic        out_ready[2];
  logic        iready   [2];
  logic        ovld     [2];
  logic [11:0] od       [2];
  logic [1:0]  omd      [2];
  logic        oov      [2];

  logic [11:0] od0;
  logic [7:0]  od1;

  int checks;
  int failures;

  code_convert_seq #(.WIDTH(8), .DIGITS(3)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(iready[0]), .in_data(in_data[0]), .in_mode(in_mode[0]),
    .out_valid(ovld[0]), .out_ready(out_ready[0]), .out_data(od0), .out_mode(omd[0]),
    .overflow(oov[0])
  );

  code_convert_seq #(.WIDTH(8), .DIGITS(2)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(iready[1]), .in_data(in_data[1]), .in_mode(in_mode[1]),
    .out_valid(ovld[1]), .out_ready(out_ready[1]), .out_data(od1), .out_mode(omd[1]),
    .overflow(oov[1])
  );

  assign od[0] = od0;
  assign od[1] = {4'h0, od1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits from plain division, Gray from the xor rule.
  task automatic model(input int d, input logic [7:0] v, input logic [1:0] m,
                       output logic [11:0] r, output logic ov);
    int nd;
    int lim;
    int x;
    int dig;
    nd  = (d == 1) ? 2 : 3;
    lim = (d == 1) ? 100 : 1000;
    r   = 12'h0;
    ov  = 1'b0;
    if (m == 2'b01) begin
      r = {4'h0, v ^ (v >> 1)};
    end else begin
      x  = int'(v) % lim;
      ov = (int'(v) >= lim);
      for (int i = 0; i < nd; i++) begin
        dig = x % 10;
        x   = x / 10;
        if (m == 2'b10) dig = dig + 3;
        if (m == 2'b11) dig = dig + 5;
        r = r | (12'(dig) << (4 * i));
      end
    end
  endtask

  // Runs one transaction with out_ready high; perturbs inputs right after acceptance.
  task automatic xact(input int d, input logic [7:0] data, input logic [1:0] mode,
                      output int lat, output logic [11:0] res, output logic ov, output logic [1:0] om);
    int k;
    out_ready[d] = 1'b1;
    in_valid[d]  = 1'b1;
    in_data[d]   = data;
    in_mode[d]   = mode;
    k = 0;
    while (!iready[d] && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("in_ready_wait", 32'(iready[d]), 32'd1);
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    in_data[d]  = ~data;
    in_mode[d]  = mode ^ 2'b01;
    lat = 1;
    while (!ovld[d] && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = od[d];
    ov  = oov[d];
    om  = omd[d];
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_done", 32'(iready[d]), 32'd1);
  endtask

  typedef struct {
    int          d;
    logic [7:0]  data;
    logic [1:0]  mode;
    logic [11:0] exp;
    logic        ov;
    int          lat;
  } vec_t;

  vec_t        tbl[9];
  int          lat;
  logic [11:0] res;
  logic [11:0] exp_r;
  logic        ov;
  logic        exp_ov;
  logic [1:0]  om;
  int          seen;
  int          k;
  int          rd;
  logic [7:0]  rdata;
  logic [1:0]  rmode;

  initial begin
    checks   = 0;
    failures = 0;
    tbl[0] = '{0, 8'd255, 2'b00, 12'h255, 1'b0, 9};
    tbl[1] = '{0, 8'd9,   2'b10, 12'h33C, 1'b0, 9};
    tbl[2] = '{0, 8'd47,  2'b11, 12'h59C, 1'b0, 9};
    tbl[3] = '{0, 8'd0,   2'b10, 12'h333, 1'b0, 9};
    tbl[4] = '{0, 8'hB4,  2'b01, 12'h0EE, 1'b0, 1};
    tbl[5] = '{1, 8'd99,  2'b00, 12'h099, 1'b0, 9};
    tbl[6] = '{1, 8'd200, 2'b00, 12'h000, 1'b1, 9};
    tbl[7] = '{1, 8'd123, 2'b00, 12'h023, 1'b1, 9};
    tbl[8] = '{0, 8'd128, 2'b00, 12'h128, 1'b0, 9};

    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = 8'h00;
      in_mode[i]   = 2'b00;
      out_ready[i] = 1'b1;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_in_ready",  32'(iready[i]), 32'd1);
      chk("reset_out_valid", 32'(ovld[i]),   32'd0);
      chk("reset_out_data",  32'(od[i]),     32'd0);
      chk("reset_out_mode",  32'(omd[i]),    32'd0);
      chk("reset_overflow",  32'(oov[i]),    32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      xact(tbl[i].d, tbl[i].data, tbl[i].mode, lat, res, ov, om);
      chk($sformatf("vec%0d_data", i),     32'(res), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_overflow", i), 32'(ov),  32'(tbl[i].ov));
      chk($sformatf("vec%0d_mode", i),     32'(om),  32'(tbl[i].mode));
      chk($sformatf("vec%0d_latency", i),  32'(lat), 32'(tbl[i].lat));
    end

    // Backpressure: result held in DONE while out_ready stays low.
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_data[0]   = 8'd37;
    in_mode[0]   = 2'b00;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    k = 0;
    while (!ovld[0] && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(ovld[0]),   32'd1);
      chk("bp_out_data",  32'(od[0]),     32'h037);
      chk("bp_overflow",  32'(oov[0]),    32'd0);
      chk("bp_in_ready",  32'(iready[0]), 32'd0);
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready",  32'(iready[0]), 32'd1);
    chk("bp_release_out_valid", 32'(ovld[0]),   32'd0);
    @(negedge clk);
    xact(0, 8'd200, 2'b00, lat, res, ov, om);
    chk("bp_next_data", 32'(res), 32'h200);

    // Reset during CONV aborts the word.
    in_valid[0] = 1'b1;
    in_data[0]  = 8'd99;
    in_mode[0]  = 2'b00;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_in_ready",  32'(iready[0]), 32'd1);
    chk("rst_mid_out_valid", 32'(ovld[0]),   32'd0);
    chk("rst_mid_out_data",  32'(od[0]),     32'd0);
    chk("rst_mid_out_mode",  32'(omd[0]),    32'd0);
    chk("rst_mid_overflow",  32'(oov[0]),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (ovld[0]) seen = 1;
    end
    chk("rst_mid_no_result", 32'(seen), 32'd0);
    @(negedge clk);
    xact(0, 8'd128, 2'b00, lat, res, ov, om);
    chk("rst_after_data", 32'(res), 32'h128);

    for (int n = 0; n < 40; n++) begin
      rd    = int'($urandom_range(0, 1));
      rdata = 8'($urandom_range(0, 255));
      rmode = 2'($urandom_range(0, 3));
      model(rd, rdata, rmode, exp_r, exp_ov);
      xact(rd, rdata, rmode, lat, res, ov, om);
      chk($sformatf("rand%0d_data", n),     32'(res), 32'(exp_r));
      chk($sformatf("rand%0d_overflow", n), 32'(ov),  32'(exp_ov));
      chk($sformatf("rand%0d_mode", n),     32'(om),  32'(rmode));
      chk($sformatf("rand%0d_latency", n),  32'(lat), (rmode == 2'b01) ? 32'd1 : 32'd9);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
